syncbram_fifo_param: RTL

//  Parametrised synchronous single-clock FIFO on inferred block RAM; successor to the fixed 8x8 FIFO.

---
 rtl/syncbram_fifo_param_if.sv | 32 +++
 rtl/syncbram_fifo_param.sv | 115 +++++++++++
 2 files changed

// File: rtl/syncbram_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer pair and syncbram_fifo_param.
// master = the datapath driving the FIFO, slave = the FIFO itself.
interface syncbram_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] buf_in;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] buf_out;
  logic              rd_valid;
  logic              buf_empty;
  logic              buf_full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fill_cnt;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, buf_in, rd_en, clr_err,
    input  buf_out, rd_valid, buf_empty, buf_full, almost_full, almost_empty,
           fill_cnt, overflow, underflow
  );

  modport slave (
    input  wr_en, buf_in, rd_en, clr_err,
    output buf_out, rd_valid, buf_empty, buf_full, almost_full, almost_empty,
           fill_cnt, overflow, underflow
  );
endinterface

// File: rtl/syncbram_fifo_param.sv
// Parametrised single-clock FIFO on inferred block RAM with occupancy, thresholds and sticky errors.
// Define SYNCBRAM_FIFO_FWFT_EN for a first-word-fall-through output stage.
module syncbram_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  syncbram_fifo_param_if.slave  bus
);
  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] buf_out_q;

  logic buf_full, buf_empty, wr_acc, rd_acc, ram_rd;

  // Acceptance and RAM-read decisions use flag values from the start of the cycle.
  always_comb begin
    buf_full  = (fill_cnt_q == PTR_W'(DEPTH));
    buf_empty = 1'b1;
    rd_acc    = 1'b0;
    ram_rd    = 1'b0;
    wr_acc    = bus.wr_en && !buf_full;
`ifdef SYNCBRAM_FIFO_FWFT_EN
    buf_empty = !rd_valid_q;
    rd_acc    = bus.rd_en && rd_valid_q;
    ram_rd    = (rd_ptr_q != wr_ptr_q) && (!rd_valid_q || rd_acc);
`else
    buf_empty = (fill_cnt_q == '0);
    rd_acc    = bus.rd_en && !buf_empty;
    ram_rd    = rd_acc;
`endif
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (ram_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_acc, rd_acc})
      2'b10:   fill_cnt_d = fill_cnt_q + PTR_W'(1);
      2'b01:   fill_cnt_d = fill_cnt_q - PTR_W'(1);
      default: fill_cnt_d = fill_cnt_q;
    endcase

`ifdef SYNCBRAM_FIFO_FWFT_EN
    if (ram_rd)      rd_valid_d = 1'b1;
    else if (rd_acc) rd_valid_d = 1'b0;
    else             rd_valid_d = rd_valid_q;
`else
    rd_valid_d = rd_acc;
`endif

    // A new error event wins over a simultaneous clear.
    if (bus.wr_en && buf_full)       overflow_d = 1'b1;
    else if (bus.clr_err)            overflow_d = 1'b0;
    if (bus.rd_en && buf_empty)      underflow_d = 1'b1;
    else if (bus.clr_err)            underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM array and its registered read port kept in plain form so tools infer block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.buf_in;
  end

  always_ff @(posedge clk) begin
    if (rst)         buf_out_q <= '0;
    else if (ram_rd) buf_out_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign bus.buf_out      = buf_out_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.buf_empty    = buf_empty;
  assign bus.buf_full     = buf_full;
  assign bus.almost_full  = (fill_cnt_q >= PTR_W'(AFULL_TH));
  assign bus.almost_empty = (fill_cnt_q <= PTR_W'(AEMPTY_TH));
  assign bus.fill_cnt     = fill_cnt_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
